// File: rtl/mult_acc_dump.sv
// rtl/mult_acc_dump.sv - integrate-and-dump accumulator behind a signed multiplier
//
// Purpose: sums acc_len consecutive valid signed products, emits one scaled
// result per frame and restarts from zero. Back-to-back frames run with no gap.
// Build option: define MULT_ACC_DUMP_SAT_EN to saturate the scaled result and
// flag clipping on dout_ovf; otherwise the result wraps and dout_ovf is 0.
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   din         signed product (DIN_WIDTH)
//   din_valid   din qualifier, every valid beat is consumed
//   acc_len     products per dump, sampled on the first beat of a frame (0 acts as 1)
//   sync_in     frame restart strobe
//   dout        signed scaled sum (DOUT_WIDTH), holds between pulses
//   dout_valid  one-cycle pulse per completed frame
//   dout_ovf    one-cycle pulse with dout_valid when the result was clipped
module mult_acc_dump #(
    parameter int DIN_WIDTH  = 32,
    parameter int ACC_WIDTH  = 48,
    parameter int DOUT_WIDTH = 32,
    parameter int DOUT_SHIFT = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    input  logic [LEN_WIDTH-1:0]  acc_len,
    input  logic                  sync_in,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_ovf
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    // Input register stage: isolates the multiplier output from the adder and
    // gives the two-cycle beat-to-dout latency together with the dump register.
    logic [DIN_WIDTH-1:0] din_q;
    logic                 din_valid_q;
    logic                 sync_q;
    logic [LEN_WIDTH-1:0] acc_len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q       <= '0;
            din_valid_q <= 1'b0;
            sync_q      <= 1'b0;
            acc_len_q   <= '0;
        end else begin
            din_q       <= din;
            din_valid_q <= din_valid;
            sync_q      <= sync_in;
            acc_len_q   <= acc_len;
        end
    end

    logic [0:0]                  state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_WIDTH-1:0]        count_q, count_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic signed [ACC_WIDTH-1:0] fin_q, fin_d;
    logic                        fin_v_q, fin_v_d;

    logic signed [ACC_WIDTH-1:0] din_ext;
    logic [LEN_WIDTH-1:0]        len_eff;

    assign din_ext = ACC_WIDTH'($signed(din_q));
    assign len_eff = (acc_len_q == '0) ? LEN_ONE : acc_len_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        fin_d   = fin_q;
        fin_v_d = 1'b0;

        // sync_in behaves like IDLE: a coincident valid beat starts the new
        // frame, which also discards a frame that would have ended this cycle.
        if (sync_q || (state_q == S_IDLE)) begin
            if (din_valid_q) begin
                len_d = len_eff;
                if (len_eff == LEN_ONE) begin
                    fin_d   = din_ext;
                    fin_v_d = 1'b1;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_IDLE;
                end else begin
                    acc_d   = din_ext;
                    count_d = LEN_ONE;
                    state_d = S_ACCUM;
                end
            end else begin
                acc_d   = '0;
                count_d = '0;
                state_d = S_IDLE;
            end
        end else if (din_valid_q) begin
            if (count_q == len_q - LEN_ONE) begin
                fin_d   = acc_q + din_ext;
                fin_v_d = 1'b1;
                acc_d   = '0;
                count_d = '0;
                state_d = S_IDLE;
            end else begin
                acc_d   = acc_q + din_ext;
                count_d = count_q + LEN_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            fin_q   <= '0;
            fin_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            fin_q   <= fin_d;
            fin_v_q <= fin_v_d;
        end
    end

    // Output scaling
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [DOUT_WIDTH-1:0]       dout_d;
    logic                        clip;

    assign shifted = fin_q >>> DOUT_SHIFT;

`ifdef MULT_ACC_DUMP_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        dout_d = shifted[DOUT_WIDTH-1:0];
        clip   = 1'b0;
        if (shifted > SAT_MAX) begin
            dout_d = SAT_MAX[DOUT_WIDTH-1:0];
            clip   = 1'b1;
        end else if (shifted < SAT_MIN) begin
            dout_d = SAT_MIN[DOUT_WIDTH-1:0];
            clip   = 1'b1;
        end
    end
`else
    assign dout_d = shifted[DOUT_WIDTH-1:0];
    assign clip   = 1'b0;
`endif

    logic [DOUT_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;
    logic                  dout_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_ovf_q   <= 1'b0;
        end else begin
            dout_valid_q <= fin_v_q;
            dout_ovf_q   <= fin_v_q & clip;
            if (fin_v_q) begin
                dout_q <= dout_d;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_ovf   = dout_ovf_q;

endmodule

// File: tb/tb_mult_acc_dump.sv
// tb/tb_mult_acc_dump.sv - randomized frame-level check of mult_acc_dump
module tb_mult_acc_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic [15:0] acc_len = 16'd4;
    logic        sync_in = 1'b0;

    logic [15:0] dout_a;
    logic        dv_a, ovf_a;
    logic [31:0] dout_b;
    logic        dv_b, ovf_b;

    always #5 clk = ~clk;

    // Narrow output, no shift: exercises clipping / wrapping.
    mult_acc_dump #(
        .DIN_WIDTH(32), .ACC_WIDTH(48), .DOUT_WIDTH(16), .DOUT_SHIFT(0), .LEN_WIDTH(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .acc_len(acc_len),
        .sync_in(sync_in), .dout(dout_a), .dout_valid(dv_a), .dout_ovf(ovf_a)
    );

    // Default parameters: exercises the arithmetic shift.
    mult_acc_dump u_dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .acc_len(acc_len),
        .sync_in(sync_in), .dout(dout_b), .dout_valid(dv_b), .dout_ovf(ovf_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: frame sums as plain arithmetic, completed frames delayed two edges.
    bit                 active = 1'b0;
    logic signed [47:0] sum;
    int                 cnt, flen;
    bit                 pv [2];
    logic signed [47:0] ps [2];
    logic [15:0]        exp_da = '0;
    logic [31:0]        exp_db = '0;
    bit                 exp_v = 1'b0, exp_oa = 1'b0, exp_ob = 1'b0;

    function automatic logic [63:0] scale(input logic signed [47:0] s, input int shift,
                                          input int dw, output bit ovf);
        longint sh, maxv, minv;
        logic [63:0] r;
        sh   = longint'(s) >>> shift;
        maxv = (longint'(1) <<< (dw - 1)) - 1;
        minv = -(longint'(1) <<< (dw - 1));
        ovf  = 1'b0;
`ifdef MULT_ACC_DUMP_SAT_EN
        if (sh > maxv) begin
            sh = maxv; ovf = 1'b1;
        end else if (sh < minv) begin
            sh = minv; ovf = 1'b1;
        end
`endif
        r = sh;
        return r & ((64'd1 << dw) - 64'd1);
    endfunction

    task automatic step(input bit v, input logic [31:0] d, input logic [15:0] len,
                        input bit s, input bit r);
        bit                 em;
        bit                 o;
        logic signed [47:0] es;
        logic signed [47:0] dx;
        logic [63:0]        tmp;
        @(negedge clk);
        rst = r; din_valid = v; din = d; acc_len = len; sync_in = s;
        @(posedge clk);
        em = 1'b0;
        es = '0;
        dx = $signed(d);
        if (r) begin
            active = 1'b0;
            pv[0] = 1'b0; pv[1] = 1'b0;
            exp_v = 1'b0; exp_oa = 1'b0; exp_ob = 1'b0;
            exp_da = '0; exp_db = '0;
        end else begin
            exp_v = pv[1];
            exp_oa = 1'b0;
            exp_ob = 1'b0;
            if (pv[1]) begin
                tmp = scale(ps[1], 0, 16, o);  exp_da = tmp[15:0]; exp_oa = o;
                tmp = scale(ps[1], 16, 32, o); exp_db = tmp[31:0]; exp_ob = o;
            end
            pv[1] = pv[0];
            ps[1] = ps[0];
            if (s || !active) begin
                if (v) begin
                    flen = (len == 16'd0) ? 1 : int'(len);
                    sum  = dx;
                    cnt  = 1;
                    if (flen == 1) begin
                        em = 1'b1; es = sum; active = 1'b0;
                    end else begin
                        active = 1'b1;
                    end
                end else if (s) begin
                    active = 1'b0;
                end
            end else if (v) begin
                sum = sum + dx;
                cnt++;
                if (cnt == flen) begin
                    em = 1'b1; es = sum; active = 1'b0;
                end
            end
            pv[0] = em;
            ps[0] = es;
        end
        #1;
        check("dv_a", 64'(dv_a), 64'(exp_v));
        check("dout_a", 64'(dout_a), 64'(exp_da));
        check("ovf_a", 64'(ovf_a), 64'(exp_oa));
        check("dv_b", 64'(dv_b), 64'(exp_v));
        check("dout_b", 64'(dout_b), 64'(exp_db));
        check("ovf_b", 64'(ovf_b), 64'(exp_ob));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 16'd4, 1'b0, 1'b0);
    endtask

    initial begin
        bit          rv, rs, rr;
        logic [31:0] rd;
        logic [15:0] rl;

        pv[0] = 1'b0; pv[1] = 1'b0;
        step(1'b0, 32'd0, 16'd4, 1'b0, 1'b1);
        step(1'b0, 32'd0, 16'd4, 1'b0, 1'b1);
        idle(1);

        // Contiguous 4-beat frame
        for (int k = 1; k <= 4; k++) step(1'b1, 32'(k), 16'd4, 1'b0, 1'b0);
        idle(3);
        check("t1_dout", 64'(dout_a), 64'd10);

        // Gapped 3-beat frame
        step(1'b1, -32'sd5, 16'd3, 1'b0, 1'b0); idle(2);
        step(1'b1, 32'sd7, 16'd3, 1'b0, 1'b0);  idle(2);
        step(1'b1, -32'sd9, 16'd3, 1'b0, 1'b0); idle(3);
        check("t2_dout", 64'(dout_a), 64'hFFF9);

        // Length 1, back-to-back dumps
        for (int k = 1; k <= 6; k++) step(1'b1, 32'(k * 3), 16'd1, 1'b0, 1'b0);
        idle(3);

        // Sync drops a partial frame
        for (int k = 0; k < 5; k++) step(1'b1, 32'd9, 16'd8, 1'b0, 1'b0);
        step(1'b0, 32'd0, 16'd8, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b1, 32'd2, 16'd8, 1'b0, 1'b0);
        idle(3);
        check("t4_dout", 64'(dout_a), 64'd16);

        // Output range limit on the narrow instance
        step(1'b1, 32'd30000, 16'd2, 1'b0, 1'b0);
        step(1'b1, 32'd30000, 16'd2, 1'b0, 1'b0);
        idle(3);
`ifdef MULT_ACC_DUMP_SAT_EN
        check("t5_dout", 64'(dout_a), 64'h7FFF);
`else
        check("t5_dout", 64'(dout_a), 64'hEA60);
`endif

        // Reset mid-frame
        step(1'b1, 32'd1, 16'd4, 1'b0, 1'b0);
        step(1'b1, 32'd1, 16'd4, 1'b0, 1'b0);
        step(1'b1, 32'd1, 16'd4, 1'b0, 1'b1);
        idle(3);
        check("t6_rst_dout", 64'(dout_a), 64'd0);
        for (int k = 0; k < 4; k++) step(1'b1, 32'd1, 16'd4, 1'b0, 1'b0);
        idle(3);
        check("t6_dout", 64'(dout_a), 64'd4);

        // Sync coinciding with a last beat starts a new frame instead
        for (int k = 0; k < 2; k++) step(1'b1, 32'd5, 16'd3, 1'b0, 1'b0);
        step(1'b1, 32'd7, 16'd2, 1'b1, 1'b0);
        step(1'b1, 32'd8, 16'd3, 1'b0, 1'b0);
        idle(3);
        check("sync_last_dout", 64'(dout_a), 64'd15);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rv = ($urandom % 10) < 7;
            rd = ($urandom % 2) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
            rl = 16'($urandom_range(0, 6));
            rs = ($urandom % 40) == 0;
            rr = ($urandom % 300) == 0;
            step(rv, rd, rl, rs, rr);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
